// File: rtl/branch_flush_sequencer.sv
// rtl/branch_flush_sequencer.sv - predict-not-taken branch resolution, flush and stall sequencer
module branch_flush_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_branch,
  input  logic             ex_resolve_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             pc_load,
  output logic [31:0]      pc_load_addr,
  output logic             pc_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             branch_control_out,
  output logic             err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {IDLE, WAIT_RES, FLUSH} state_t;

  // Timeout fires when the wait counter would step onto TIMEOUT-1.
  localparam logic [7:0]       WAIT_LAST  = 8'(TIMEOUT - 2);
  localparam logic [3:0]       FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [7:0]       wait_q, wait_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             pc_load_q, pc_load_d;
  logic [31:0]      addr_q, addr_d;
  logic             flush_q, flush_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] bc_q, bc_d;
  logic [CNT_W-1:0] tc_q, tc_d;

  // State and registered outputs; reset aborts any in-flight sequence.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      wait_q      <= '0;
      flush_cnt_q <= '0;
      pc_load_q   <= 1'b0;
      addr_q      <= '0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      bc_q        <= '0;
      tc_q        <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      wait_q      <= wait_d;
      flush_cnt_q <= flush_cnt_d;
      pc_load_q   <= pc_load_d;
      addr_q      <= addr_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
      bc_q        <= bc_d;
      tc_q        <= tc_d;
    end
  end

  // Next-state and next-output decode; the redirect and flush strobes default low.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    wait_d      = wait_q;
    flush_cnt_d = flush_cnt_q;
    pc_load_d   = 1'b0;
    addr_d      = addr_q;
    flush_d     = 1'b0;
    err_d       = err_q;
    bc_d        = bc_q;
    tc_d        = tc_q;
    case (state_q)
      IDLE: begin
        if (ex_resolve_valid) err_d = 1'b1;
        if (id_branch) begin
          state_d   = WAIT_RES;
          wait_d    = '0;
          pending_d = 1'b0;
        end
      end
      WAIT_RES: begin
        if (ex_resolve_valid) begin
          if (bc_q != CNT_MAX) bc_d = bc_q + 1'b1;
          pending_d = 1'b0;
          if (ex_taken) begin
            // Any pending branch is on the wrong path and is dropped.
            if (tc_q != CNT_MAX) tc_d = tc_q + 1'b1;
            state_d     = FLUSH;
            flush_cnt_d = '0;
            pc_load_d   = 1'b1;
            addr_d      = ex_target;
            flush_d     = 1'b1;
          end else if (pending_q || id_branch) begin
            // The queued (or simultaneously decoded) branch becomes the outstanding one.
            wait_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d     = 1'b1;
          state_d   = IDLE;
          pending_d = 1'b0;
        end else begin
          wait_d = wait_q + 8'd1;
          if (id_branch) pending_d = 1'b1;
        end
      end
      FLUSH: begin
        if (ex_resolve_valid) err_d = 1'b1;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = IDLE;
        end else begin
          flush_d     = 1'b1;
          flush_cnt_d = flush_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc_load            = pc_load_q;
  assign branch_control_out = pc_load_q;
  assign pc_load_addr       = addr_q;
  assign pc_stall           = pending_q;
  assign ifid_flush         = flush_q;
  assign idex_flush         = flush_q;
  assign err                = err_q;
  assign branch_count       = bc_q;
  assign taken_count        = tc_q;

endmodule

// File: tb/tb_branch_flush_sequencer.sv
// tb/tb_branch_flush_sequencer.sv - directed vector bench for branch_flush_sequencer
module tb_branch_flush_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_branch, ex_resolve_valid, ex_taken;
  logic [31:0] ex_target;

  logic        pc_load, pc_stall, ifid_flush, idex_flush, branch_control_out, err;
  logic [31:0] pc_load_addr;
  logic [15:0] branch_count, taken_count;

  logic        pc_load4, pc_stall4, ifid_flush4, idex_flush4, branch_control_out4, err4;
  logic [31:0] pc_load_addr4;
  logic [3:0]  branch_count4, taken_count4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  branch_flush_sequencer dut (
    .clock(clock), .reset_n(reset_n), .id_branch(id_branch),
    .ex_resolve_valid(ex_resolve_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc_stall(pc_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .branch_control_out(branch_control_out), .err(err),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  branch_flush_sequencer #(.CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .id_branch(id_branch),
    .ex_resolve_valid(ex_resolve_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .pc_load(pc_load4), .pc_load_addr(pc_load_addr4), .pc_stall(pc_stall4),
    .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .branch_control_out(branch_control_out4), .err(err4),
    .branch_count(branch_count4), .taken_count(taken_count4)
  );

  typedef struct {
    logic        id, rv, tk;
    logic [31:0] tgt;
    logic        ld;
    logic [31:0] addr;
    logic        stall, fl, er;
    int          bc, tc;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t v(logic id, logic rv, logic tk, logic [31:0] tgt,
                             logic ld, logic [31:0] addr, logic stall, logic fl,
                             logic er, int bc, int tc);
    vec_t r;
    r.id = id; r.rv = rv; r.tk = tk; r.tgt = tgt;
    r.ld = ld; r.addr = addr; r.stall = stall; r.fl = fl; r.er = er;
    r.bc = bc; r.tc = tc;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(logic id, logic rv, logic tk, logic [31:0] tgt);
    id_branch = id; ex_resolve_valid = rv; ex_taken = tk; ex_target = tgt;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic check_all(string tag, logic ld, logic [31:0] addr, logic stall,
                           logic fl, logic er, int bc, int tc);
    check({tag, " pc_load"}, 32'(pc_load), 32'(ld));
    check({tag, " branch_control_out"}, 32'(branch_control_out), 32'(ld));
    check({tag, " pc_load_addr"}, pc_load_addr, addr);
    check({tag, " pc_stall"}, 32'(pc_stall), 32'(stall));
    check({tag, " ifid_flush"}, 32'(ifid_flush), 32'(fl));
    check({tag, " idex_flush"}, 32'(idex_flush), 32'(fl));
    check({tag, " err"}, 32'(err), 32'(er));
    check({tag, " branch_count"}, 32'(branch_count), 32'(bc));
    check({tag, " taken_count"}, 32'(taken_count), 32'(tc));
  endtask

  initial begin
    //          id rv tk target         ld addr           st fl er bc tc
    vecs[0]  = v(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 0);
    vecs[1]  = v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 0);
    vecs[2]  = v(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 0);
    vecs[3]  = v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 0);
    vecs[4]  = v(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 0);
    vecs[5]  = v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 0);
    vecs[6]  = v(0, 1, 1, 32'h00400100, 1, 32'h00400100, 0, 1, 0, 2, 1);
    vecs[7]  = v(0, 0, 0, 32'h0,        0, 32'h00400100, 0, 1, 0, 2, 1);
    vecs[8]  = v(0, 0, 0, 32'h0,        0, 32'h00400100, 0, 0, 0, 2, 1);
    vecs[9]  = v(1, 0, 0, 32'h0,        0, 32'h00400100, 0, 0, 0, 2, 1);
    vecs[10] = v(1, 0, 0, 32'h0,        0, 32'h00400100, 1, 0, 0, 2, 1);
    vecs[11] = v(0, 0, 0, 32'h0,        0, 32'h00400100, 1, 0, 0, 2, 1);
    vecs[12] = v(0, 1, 0, 32'h0,        0, 32'h00400100, 0, 0, 0, 3, 1);
    vecs[13] = v(0, 0, 0, 32'h0,        0, 32'h00400100, 0, 0, 0, 3, 1);
    vecs[14] = v(0, 1, 1, 32'h00400200, 1, 32'h00400200, 0, 1, 0, 4, 2);
    vecs[15] = v(1, 0, 0, 32'h0,        0, 32'h00400200, 0, 1, 0, 4, 2);
    vecs[16] = v(0, 0, 0, 32'h0,        0, 32'h00400200, 0, 0, 0, 4, 2);
    vecs[17] = v(0, 1, 1, 32'hdeadbeef, 0, 32'h00400200, 0, 0, 1, 4, 2);
    vecs[18] = v(1, 0, 0, 32'h0,        0, 32'h00400200, 0, 0, 1, 4, 2);
    vecs[19] = v(1, 1, 0, 32'h0,        0, 32'h00400200, 0, 0, 1, 5, 2);
    vecs[20] = v(0, 1, 1, 32'h12345678, 1, 32'h12345678, 0, 1, 1, 6, 3);
    vecs[21] = v(0, 1, 0, 32'h0,        0, 32'h12345678, 0, 1, 1, 6, 3);
    vecs[22] = v(0, 0, 0, 32'h0,        0, 32'h12345678, 0, 0, 1, 6, 3);

    reset_n = 1'b0;
    id_branch = 0; ex_resolve_valid = 0; ex_taken = 0; ex_target = '0;
    @(posedge clock);
    #1;

    // Reset held with random inputs.
    for (int i = 0; i < 2; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    check_all("reset", 0, 32'h0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(0, 0, 0, 32'h0);
    check_all("post_reset", 0, 32'h0, 0, 0, 0, 0, 0);

    // Main cycle-by-cycle vector table.
    for (int i = 0; i < 23; i++) begin
      step(vecs[i].id, vecs[i].rv, vecs[i].tk, vecs[i].tgt);
      check_all($sformatf("v%0d", i), vecs[i].ld, vecs[i].addr, vecs[i].stall,
                vecs[i].fl, vecs[i].er, vecs[i].bc, vecs[i].tc);
    end

    // Reset in the middle of a flush clears everything, including sticky err.
    step(1, 0, 0, 32'h0);
    step(0, 1, 1, 32'h0000abcd);
    check("midrst flush_active", 32'(ifid_flush), 32'd1);
    reset_n = 1'b0;
    step(0, 0, 0, 32'h0);
    check_all("midrst", 0, 32'h0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(0, 0, 0, 32'h0);
    check("midrst idle flush", 32'(ifid_flush), 32'd0);

    // Timeout: branch at t0 with no resolution raises err at t8.
    do_reset();
    step(1, 0, 0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("timeout err t%0d", k), 32'(err), (k == 8) ? 32'd1 : 32'd0);
      if (k < 8) step(0, 0, 0, 32'h0);
    end
    check("timeout counts", 32'(branch_count), 32'd0);
    step(1, 0, 0, 32'h0);
    step(0, 1, 1, 32'h00000040);
    check_all("after_timeout", 1, 32'h00000040, 0, 1, 1, 1, 1);

    // Saturation: 17 taken branches on a 4-bit and a 16-bit counter instance.
    do_reset();
    for (int n = 0; n < 17; n++) begin
      step(1, 0, 0, 32'h0);
      step(0, 1, 1, 32'h00000100);
      step(0, 0, 0, 32'h0);
      step(0, 0, 0, 32'h0);
    end
    check("sat4 taken_count", 32'(taken_count4), 32'd15);
    check("sat4 branch_count", 32'(branch_count4), 32'd15);
    check("sat4 err", 32'(err4), 32'd0);
    check("sat16 taken_count", 32'(taken_count), 32'd17);
    check("sat16 branch_count", 32'(branch_count), 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
